// File: rtl/psram_burst_ctrl.sv
// Fixed-length synchronous burst controller for the multiplexed CRAM/PSRAM port.
// Pin controls decode from the state register and the latched request, so they are glitch-free into the IOBs.
module psram_burst_ctrl #(
    parameter int LATENCY   = 3,
    parameter int BURST_LEN = 4,
    parameter int WAIT_MAX  = 15
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req,
    input  logic        we,
    input  logic [21:0] addr,
    input  logic [1:0]  be,
    input  logic [15:0] wdata,
    output logic        ready,
    output logic        wnext,
    output logic [15:0] rdata,
    output logic        rvalid,
    output logic        done,
    output logic        err,
    output logic [5:0]  cram_a_hi,
    output logic        cram_adv_n,
    output logic        cram_ce_n,
    output logic        cram_oe_n,
    output logic        cram_we_n,
    output logic        cram_ub_n,
    output logic        cram_lb_n,
    output logic [15:0] dq_out,
    output logic        dq_oe,
    output logic        clk_en,
    input  logic        wait_q,
    input  logic [15:0] dq_in_q
);

    // state  | meaning
    // S_IDLE | ready for a request, CE high
    // S_ADDR | ADV cycle, address on DQ and A[21:16]
    // S_LAT  | initial access latency countdown
    // S_DATA | one beat per cycle without WAIT
    // S_END  | CE high recovery, done/err pulse
    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_LAT, S_DATA, S_END} state_t;

    localparam logic [3:0] LAT_LOAD  = 4'((LATENCY > 1) ? LATENCY - 2 : 0);
    localparam logic [4:0] LAST_BEAT = 5'(BURST_LEN - 1);
    localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

    state_t      st, st_nxt;
    logic        we_r, we_nxt;
    logic [21:0] addr_r, addr_nxt;
    logic [1:0]  be_r, be_nxt;
    logic [3:0]  lat_cnt, lat_nxt;
    logic [4:0]  beat_cnt, beat_nxt;
    logic [7:0]  wait_cnt, wait_nxt;
    logic        abort_r, abort_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st       <= S_IDLE;
            we_r     <= 1'b0;
            addr_r   <= '0;
            be_r     <= '0;
            lat_cnt  <= '0;
            beat_cnt <= '0;
            wait_cnt <= '0;
            abort_r  <= 1'b0;
        end else begin
            st       <= st_nxt;
            we_r     <= we_nxt;
            addr_r   <= addr_nxt;
            be_r     <= be_nxt;
            lat_cnt  <= lat_nxt;
            beat_cnt <= beat_nxt;
            wait_cnt <= wait_nxt;
            abort_r  <= abort_nxt;
        end
    end

    always_comb begin
        st_nxt    = st;
        we_nxt    = we_r;
        addr_nxt  = addr_r;
        be_nxt    = be_r;
        lat_nxt   = lat_cnt;
        beat_nxt  = beat_cnt;
        wait_nxt  = wait_cnt;
        abort_nxt = abort_r;
        case (st)
            S_IDLE: begin
                if (req) begin
                    st_nxt   = S_ADDR;
                    we_nxt   = we;
                    addr_nxt = addr;
                    be_nxt   = be;
                end
            end
            S_ADDR: begin
                beat_nxt  = '0;
                wait_nxt  = '0;
                abort_nxt = 1'b0;
                lat_nxt   = LAT_LOAD;
                st_nxt    = (LATENCY > 1) ? S_LAT : S_DATA;
            end
            S_LAT: begin
                if (lat_cnt == 4'd0) st_nxt = S_DATA;
                else                 lat_nxt = lat_cnt - 4'd1;
            end
            S_DATA: begin
                if (!wait_q) begin
                    wait_nxt = '0;
                    if (beat_cnt == LAST_BEAT) st_nxt = S_END;
                    else                       beat_nxt = beat_cnt + 5'd1;
                end else if (wait_cnt == WAIT_LAST) begin
                    // timeout only wins on a cycle that is itself a wait cycle
                    st_nxt    = S_END;
                    abort_nxt = 1'b1;
                end else begin
                    wait_nxt = wait_cnt + 8'd1;
                end
            end
            S_END:   st_nxt = S_IDLE;
            default: st_nxt = S_IDLE;
        endcase
    end

    logic active, post_adv, beat;
    assign active   = (st == S_ADDR) || (st == S_LAT) || (st == S_DATA);
    assign post_adv = (st == S_LAT) || (st == S_DATA);
    assign beat     = (st == S_DATA) && !wait_q;

    assign ready      = (st == S_IDLE);
    assign cram_ce_n  = !active;
    assign cram_adv_n = (st != S_ADDR);
    assign clk_en     = active;
    assign cram_we_n  = active ? !we_r : 1'b1;
    assign cram_oe_n  = !(post_adv && !we_r);
    assign cram_ub_n  = post_adv ? !be_r[1] : 1'b1;
    assign cram_lb_n  = post_adv ? !be_r[0] : 1'b1;
    assign cram_a_hi  = (st == S_ADDR) ? addr_r[21:16] : 6'd0;
    assign dq_oe      = (st == S_ADDR) || (post_adv && we_r);
    // wdata is show-ahead and only advances on wnext, so a wait cycle holds DQ naturally
    assign dq_out     = (st == S_ADDR) ? addr_r[15:0] :
                        (post_adv && we_r) ? wdata : 16'd0;
    assign rvalid     = beat && !we_r;
    assign wnext      = beat && we_r;
    assign rdata      = rvalid ? dq_in_q : 16'd0;
    assign done       = (st == S_END);
    assign err        = (st == S_END) && abort_r;

endmodule
